// File: rtl/data_pattern_source.sv
// Burst pattern source (counter / Galois LFSR / constant / zero) for a ready/valid stream.
// Optional embedded properties: define DATA_PATTERN_SOURCE_ASSERT_EN.
module data_pattern_source #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       LEN_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  burst_len,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [1:0] {ModeCount, ModeLfsr, ModeConst, ModeZero} mode_e;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] first_word;
    logic [DATA_W-1:0] next_word;

    always_comb begin
        first_word = '0;
        unique case (mode_e'(mode))
            ModeCount: first_word = seed;
            ModeLfsr:  first_word = (seed == '0) ? DATA_W'(1) : seed;
            ModeConst: first_word = seed;
            ModeZero:  first_word = '0;
            default:   first_word = '0;
        endcase
    end

    always_comb begin
        next_word = data_q;
        unique case (mode_q)
            ModeCount: next_word = data_q + DATA_W'(1);
            ModeLfsr:  next_word = (data_q >> 1) ^ (data_q[0] ? LFSR_TAPS : '0);
            ModeConst: next_word = data_q;
            ModeZero:  next_word = data_q;
            default:   next_word = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d = StRun;
                        mode_d  = mode_e'(mode);
                        len_d   = burst_len;
                        cnt_d   = '0;
                        data_d  = first_word;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                // valid is always high in RUN, so ready alone marks a handshake
                if (ready) begin
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        data_d = next_word;
                        cnt_d  = cnt_q + LEN_W'(1);
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mode_q  <= ModeCount;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by reset directly so data reads zero in the same instant reset rises.
    assign valid = (state_q == StRun) && !reset;
    assign busy  = (state_q == StRun) && !reset;
    assign done  = (state_q == StDone) && !reset;
    assign data  = valid ? data_q : '0;

`ifdef DATA_PATTERN_SOURCE_ASSERT_EN
    p_reset_data_zero: assert property (@(posedge clk) $rose(reset) |-> data == '0)
        else $error("p_reset_data_zero");

    p_hold_under_backpressure: assert property (@(posedge clk) disable iff (reset)
        valid && !ready |=> $stable(data) && valid)
        else $error("p_hold_under_backpressure");

    p_done_single_cycle: assert property (@(posedge clk) disable iff (reset)
        done |=> !done)
        else $error("p_done_single_cycle");

    p_valid_only_when_busy: assert property (@(posedge clk) disable iff (reset)
        !busy |-> !valid)
        else $error("p_valid_only_when_busy");
`endif

endmodule
